// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - shared fabric configuration types and constants
package fabric_cfg_pkg;

   localparam int CFG_ADDR_W  = 8;
   localparam int CFG_DATA_W  = 32;
   localparam int CFG_FRAME_W = CFG_ADDR_W + CFG_DATA_W;

   // Logic block opcodes, carried in the low bits of the config word
   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_NOT = 2'd3;

   typedef enum logic [2:0] {
      CFG_IDLE  = 3'd0,
      CFG_ADDR  = 3'd1,
      CFG_DATA  = 3'd2,
      CFG_WRITE = 3'd3,
      CFG_FIN   = 3'd4
   } cfg_state_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - 40-bit MSB-first frame shift register with accept count
module cfg_shift_reg
   import fabric_cfg_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   shift_i,
   input  logic                   bit_i,
   output logic [CFG_FRAME_W-1:0] frame_o,
   output logic [5:0]             count_o
);

   logic [CFG_FRAME_W-1:0] frame_q, frame_d;
   logic [5:0]             count_q, count_d;

   // Clear wins over shift; each accepted bit enters at the LSB and bumps the count
   always_comb begin
      frame_d = frame_q;
      count_d = count_q;
      if (clear_i) begin
         frame_d = '0;
         count_d = '0;
      end else if (shift_i) begin
         frame_d = {frame_q[CFG_FRAME_W-2:0], bit_i};
         count_d = count_q + 6'd1;
      end
   end

   // Frame and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q <= '0;
         count_q <= '0;
      end else begin
         frame_q <= frame_d;
         count_q <= count_d;
      end
   end

   // The frame including this cycle's bit lets the loader capture on the final accept
   assign frame_o = frame_d;
   assign count_o = count_q;

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial bitstream loader that strobes logic block config words
module config_loader
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_BLOCKS = 16,
   parameter int ADDR_W     = CFG_ADDR_W,
   parameter int DATA_W     = CFG_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [15:0]           load_frames,
   input  logic                  bs_valid,
   input  logic                  bs_bit,
   output logic                  bs_ready,
   output logic [DATA_W-1:0]     config_data,
   output logic [NUM_BLOCKS-1:0] config_en,
   output logic                  busy,
   output logic                  done,
   output logic                  addr_err
);

   cfg_state_t             state_q, state_d;
   logic [15:0]            frames_q, frames_d;
   logic                   accept;
   logic                   shift_clear;
   logic [CFG_FRAME_W-1:0] frame_next;
   logic [5:0]             bit_cnt;
   logic [ADDR_W-1:0]      frame_addr;
   logic [DATA_W-1:0]      frame_word;
   logic                   addr_ok;
   logic [NUM_BLOCKS-1:0]  en_dec;
   logic [DATA_W-1:0]      config_data_q, config_data_d;
   logic [NUM_BLOCKS-1:0]  config_en_q, config_en_d;
   logic                   addr_err_q, addr_err_d;

   assign bs_ready = (state_q == CFG_ADDR) || (state_q == CFG_DATA);
   assign accept   = bs_valid & bs_ready;

   cfg_shift_reg u_shift (
      .clk     (clk),
      .rst     (rst),
      .clear_i (shift_clear),
      .shift_i (accept),
      .bit_i   (bs_bit),
      .frame_o (frame_next),
      .count_o (bit_cnt)
   );

   assign frame_addr = frame_next[CFG_FRAME_W-1:CFG_DATA_W];
   assign frame_word = frame_next[CFG_DATA_W-1:0];

   // One-hot decode of the incoming frame address; out-of-range addresses decode to nothing
   always_comb begin
      en_dec  = '0;
      addr_ok = int'(frame_addr) < NUM_BLOCKS;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         en_dec[i] = (int'(frame_addr) == i);
      end
   end

   // Next state plus next values of the registered strobe, word and error flag
   always_comb begin
      state_d       = state_q;
      frames_d      = frames_q;
      shift_clear   = 1'b0;
      config_data_d = config_data_q;
      config_en_d   = '0;
      addr_err_d    = addr_err_q;
      case (state_q)
         CFG_IDLE: begin
            if (load_start) begin
               shift_clear = 1'b1;
               addr_err_d  = 1'b0;
               if (load_frames != 16'd0) begin
                  frames_d = load_frames;
                  state_d  = CFG_ADDR;
               end else begin
                  state_d = CFG_FIN;
               end
            end
         end
         CFG_ADDR: begin
            if (accept && (bit_cnt == 6'd7)) begin
               state_d = CFG_DATA;
            end
         end
         CFG_DATA: begin
            if (accept && (bit_cnt == 6'd39)) begin
               state_d       = CFG_WRITE;
               config_data_d = frame_word;
               config_en_d   = en_dec;
               if (!addr_ok) begin
                  addr_err_d = 1'b1;
               end
            end
         end
         CFG_WRITE: begin
            shift_clear = 1'b1;
            frames_d    = frames_q - 16'd1;
            state_d     = (frames_q == 16'd1) ? CFG_FIN : CFG_ADDR;
         end
         CFG_FIN: begin
            state_d = CFG_IDLE;
         end
         default: begin
            state_d = CFG_IDLE;
         end
      endcase
   end

   // State, frame count and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= CFG_IDLE;
         frames_q      <= '0;
         config_data_q <= '0;
         config_en_q   <= '0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         frames_q      <= frames_d;
         config_data_q <= config_data_d;
         config_en_q   <= config_en_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign config_data = config_data_q;
   assign config_en   = config_en_q;
   assign addr_err    = addr_err_q;
   assign busy        = (state_q != CFG_IDLE);
   assign done        = (state_q == CFG_FIN);

endmodule
